reaction_test_ctrl: RTL and testbench

- Sequences one reaction-time trial after the main menu selects the reaction game.
- Waits a pseudo-random delay, then asserts the stimulus and measures user response time in milliseconds.
- Flags early presses and keeps the best (minimum) valid time.
- Outputs feed the display/score datapath; iEnable comes from the menu's react select.

---
 rtl/reaction_test_ctrl_pkg.sv | 47 ++++
 rtl/reaction_test_ctrl_if.sv | 37 +++
 rtl/reaction_test_ctrl_lfsr16.sv | 37 +++
 rtl/reaction_test_ctrl.sv | 168 ++++++++++++++++
 tb/tb_reaction_test_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/reaction_test_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reaction_test_ctrl_pkg
// Description : Shared types and constants for the reaction-time game: state
//               encodings, millisecond width and saturation helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package reaction_test_ctrl_pkg;

    localparam int                c_ms_w   = 14;
    localparam logic [c_ms_w-1:0] c_max_ms = 14'd9999;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DELAY  = 3'd1,
        ST_GO     = 3'd2,
        ST_RESULT = 3'd3,
        ST_EARLY  = 3'd4
    } state_e;

    function automatic logic [c_ms_w-1:0] ms_sat_add(
        input logic [c_ms_w-1:0] a,
        input logic [c_ms_w-1:0] b,
        input logic [c_ms_w-1:0] lim
    );
        logic [c_ms_w:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, lim}) ? lim : sum[c_ms_w-1:0];
    endfunction

    function automatic logic [c_ms_w-1:0] ms_inc_sat(
        input logic [c_ms_w-1:0] a,
        input logic [c_ms_w-1:0] lim
    );
        return (a >= lim) ? lim : a + 1'b1;
    endfunction

    function automatic logic [c_ms_w-1:0] ms_min(
        input logic [c_ms_w-1:0] a,
        input logic [c_ms_w-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reaction_test_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : reaction_test_ctrl_if
// Description : Button/status bundle between the menu/display side (master)
//               and the reaction-trial controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface reaction_test_ctrl_if;
    import reaction_test_ctrl_pkg::*;

    logic              iEnable;
    logic              iStart;
    logic              iReact;
    logic              iQuit;
    logic              oStimulus;
    logic              oTooSoon;
    logic              oResultValid;
    logic [c_ms_w-1:0] oReactMs;
    logic [c_ms_w-1:0] oBestMs;
    logic [c_ms_w-1:0] oDelayMs;
    logic [2:0]        oState;

    modport master (
        output iEnable, iStart, iReact, iQuit,
        input  oStimulus, oTooSoon, oResultValid,
        input  oReactMs, oBestMs, oDelayMs, oState
    );

    modport slave (
        input  iEnable, iStart, iReact, iQuit,
        output oStimulus, oTooSoon, oResultValid,
        output oReactMs, oBestMs, oDelayMs, oState
    );

endinterface

`default_nettype wire

// File: rtl/reaction_test_ctrl_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : lfsr16
// Description : 16-bit Fibonacci LFSR, taps 16/14/13/11, loads SEED on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_en,
    output logic      [15:0] o_lfsr
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        w_fb;

    always_comb begin
        w_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d = i_en ? {lfsr_q[14:0], w_fb} : lfsr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_lfsr = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/reaction_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reaction_test_ctrl
// Description : Runs one reaction-time trial: random delay, stimulus, ms
//               response measurement, early-press flag and best-time tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module reaction_test_ctrl
    import reaction_test_ctrl_pkg::*;
#(
    parameter int          MS_DIV       = 50000,
    parameter int          MIN_DELAY_MS = 1000,
    parameter int          DELAY_BITS   = 11,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          MAX_MS       = 9999
) (
    input  wire logic           iClock,
    input  wire logic           iReset,
    reaction_test_ctrl_if.slave bus
);

    localparam int                 c_pre_w    = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(MS_DIV - 1);
    localparam logic [c_pre_w-1:0] c_pre_one  = c_pre_w'(1);
    localparam logic [c_ms_w-1:0]  c_max      = c_ms_w'(MAX_MS);
    localparam logic [c_ms_w-1:0]  c_min      = c_ms_w'(MIN_DELAY_MS);

    state_e              state_q, state_d;
    logic                start_q, start_d;
    logic                react_q, react_d;
    logic [c_pre_w-1:0]  presc_q, presc_d;
    logic [c_ms_w-1:0]   cnt_q, cnt_d;
    logic [c_ms_w-1:0]   delay_q, delay_d;
    logic [c_ms_w-1:0]   react_ms_q, react_ms_d;
    logic [c_ms_w-1:0]   best_q, best_d;
    logic                stim_q, stim_d;
    logic                soon_q, soon_d;
    logic                valid_q, valid_d;

    logic [15:0]             w_lfsr;
    logic [DELAY_BITS-1:0]   w_rand_bits;
    logic [15-DELAY_BITS:0]  w_lfsr_unused;
    logic [c_ms_w-1:0]       w_delay_load;
    logic [c_ms_w-1:0]       w_cnt_inc;
    logic                    w_start_p;
    logic                    w_react_p;
    logic                    w_tick;
    logic                    w_abort;

    lfsr16 #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clk    (iClock),
        .rst    (iReset),
        .i_en   (1'b1),
        .o_lfsr (w_lfsr)
    );

    assign {w_lfsr_unused, w_rand_bits} = w_lfsr;
    assign w_delay_load = ms_sat_add(c_min, c_ms_w'(w_rand_bits), c_max);

    assign w_start_p = bus.iStart & ~start_q;
    assign w_react_p = bus.iReact & ~react_q;
    assign w_tick    = (presc_q == c_pre_last);
    assign w_abort   = bus.iQuit | ~bus.iEnable;
    assign w_cnt_inc = ms_inc_sat(cnt_q, c_max);

    always_comb begin
        state_d    = state_q;
        start_d    = bus.iStart;
        react_d    = bus.iReact;
        presc_d    = w_tick ? '0 : presc_q + c_pre_one;
        cnt_d      = (w_tick && state_q != ST_IDLE) ? w_cnt_inc : cnt_q;
        delay_d    = delay_q;
        react_ms_d = react_ms_q;
        best_d     = best_q;

        if (w_abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (w_start_p) begin
                        state_d = ST_DELAY;
                        delay_d = w_delay_load;
                    end
                end
                ST_DELAY: begin
                    // An early press beats delay expiry landing in the same cycle.
                    if (w_react_p) begin
                        state_d = ST_EARLY;
                    end else if (w_tick && w_cnt_inc >= delay_q) begin
                        state_d = ST_GO;
                    end
                end
                ST_GO: begin
                    // The press reports the count before any same-cycle tick.
                    if (w_react_p) begin
                        state_d    = ST_RESULT;
                        react_ms_d = cnt_q;
                        best_d     = ms_min(best_q, cnt_q);
                    end else if (w_tick && w_cnt_inc >= c_max) begin
                        state_d    = ST_RESULT;
                        react_ms_d = c_max;
                    end
                end
                ST_RESULT, ST_EARLY: begin
                    if (w_start_p) begin
                        state_d = ST_DELAY;
                        delay_d = w_delay_load;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Every state entry restarts timing so the first ms is full length.
        if (state_d != state_q) begin
            presc_d = '0;
            cnt_d   = '0;
        end

        stim_d  = (state_d == ST_GO);
        soon_d  = (state_d == ST_EARLY);
        valid_d = (state_d == ST_RESULT);
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            react_q    <= 1'b0;
            presc_q    <= '0;
            cnt_q      <= '0;
            delay_q    <= '0;
            react_ms_q <= '0;
            best_q     <= c_max;
            stim_q     <= 1'b0;
            soon_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            react_q    <= react_d;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            delay_q    <= delay_d;
            react_ms_q <= react_ms_d;
            best_q     <= best_d;
            stim_q     <= stim_d;
            soon_q     <= soon_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.oStimulus    = stim_q;
    assign bus.oTooSoon     = soon_q;
    assign bus.oResultValid = valid_q;
    assign bus.oReactMs     = react_ms_q;
    assign bus.oBestMs      = best_q;
    assign bus.oDelayMs     = delay_q;
    assign bus.oState       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_reaction_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reaction_test_ctrl
// Description : Directed self-checking bench for reaction_test_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reaction_test_ctrl;

    localparam logic [15:0] c_seed = 16'hACE1;
    localparam int          c_div  = 4;
    localparam int          c_min  = 2;
    localparam int          c_max  = 9999;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reaction_test_ctrl_if u_if ();

    reaction_test_ctrl #(
        .MS_DIV       (c_div),
        .MIN_DELAY_MS (c_min),
        .DELAY_BITS   (2),
        .LFSR_SEED    (c_seed),
        .MAX_MS       (c_max)
    ) u_dut (
        .iClock (clk),
        .iReset (rst),
        .bus    (u_if.slave)
    );

    // Reference LFSR from the documented polynomial, used to predict delay loads.
    logic [15:0] lfsr_m;
    always @(posedge clk) begin
        if (rst) lfsr_m <= c_seed;
        else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    int n_cmp = 0;
    int n_err = 0;
    int d;
    int seen;
    int k;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        check("rst_best",  int'(u_if.oBestMs), c_max);
        check("rst_react", int'(u_if.oReactMs), 0);
        check("rst_stim",  int'(u_if.oStimulus), 0);
        check("rst_state", int'(u_if.oState), 0);
        rst = 1'b0;
        step(1);
        check("post_rst_state", int'(u_if.oState), 0);
    endtask

    task automatic start_trial(input bit hold, output int dly);
        u_if.iStart = 1'b1;
        dly = c_min + int'(lfsr_m[1:0]);
        step(1);
        if (!hold) u_if.iStart = 1'b0;
        check("delay_state", int'(u_if.oState), 1);
        check("delay_load", int'(u_if.oDelayMs), dly);
    endtask

    task automatic wait_stim(input int dly);
        int cyc;
        cyc = 1;
        while (!u_if.oStimulus && cyc < 200) begin
            step(1);
            cyc++;
        end
        check("stim_latency", cyc, c_div * dly + 1);
    endtask

    task automatic react_after(input int ms);
        step(c_div * ms);
        u_if.iReact = 1'b1;
        step(1);
        u_if.iReact = 1'b0;
        check("res_state", int'(u_if.oState), 3);
        check("res_valid", int'(u_if.oResultValid), 1);
        check("res_stim",  int'(u_if.oStimulus), 0);
        check("res_ms",    int'(u_if.oReactMs), ms);
    endtask

    initial begin
        u_if.iEnable = 1'b0;
        u_if.iStart  = 1'b0;
        u_if.iReact  = 1'b0;
        u_if.iQuit   = 1'b0;
        do_reset();
        u_if.iEnable = 1'b1;
        step(1);

        // Normal trial measuring 3 ms
        start_trial(1'b0, d);
        wait_stim(d);
        react_after(3);
        check("normal_best", int'(u_if.oBestMs), 3);

        // Early press one cycle after DELAY entry
        start_trial(1'b0, d);
        check("early_pre_stim", int'(u_if.oStimulus), 0);
        u_if.iReact = 1'b1;
        step(1);
        check("early_state", int'(u_if.oState), 4);
        check("early_flag",  int'(u_if.oTooSoon), 1);
        check("early_best",  int'(u_if.oBestMs), 3);
        check("early_react", int'(u_if.oReactMs), 3);
        u_if.iReact = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (u_if.oStimulus) seen = 1;
        end
        check("early_no_stim", seen, 0);
        start_trial(1'b0, d);
        check("early_flag_clr", int'(u_if.oTooSoon), 0);
        wait_stim(d);
        react_after(4);
        check("early_best2", int'(u_if.oBestMs), 3);

        // Best tracking 7, 5, 9 from a fresh reset
        do_reset();
        start_trial(1'b0, d);
        wait_stim(d);
        react_after(7);
        check("best_7", int'(u_if.oBestMs), 7);
        start_trial(1'b0, d);
        wait_stim(d);
        react_after(5);
        check("best_5", int'(u_if.oBestMs), 5);
        start_trial(1'b0, d);
        wait_stim(d);
        react_after(9);
        check("best_9", int'(u_if.oBestMs), 5);

        // Quit during GO
        start_trial(1'b0, d);
        wait_stim(d);
        step(2);
        u_if.iQuit = 1'b1;
        step(1);
        u_if.iQuit = 1'b0;
        check("quit_state", int'(u_if.oState), 0);
        check("quit_stim",  int'(u_if.oStimulus), 0);
        check("quit_best",  int'(u_if.oBestMs), 5);
        check("quit_react", int'(u_if.oReactMs), 9);

        // Drop enable in RESULT
        start_trial(1'b0, d);
        wait_stim(d);
        react_after(6);
        u_if.iEnable = 1'b0;
        step(1);
        check("dis_state", int'(u_if.oState), 0);
        check("dis_valid", int'(u_if.oResultValid), 0);
        check("dis_best",  int'(u_if.oBestMs), 5);
        u_if.iEnable = 1'b1;
        step(1);

        // Held start: one trial only
        start_trial(1'b1, d);
        wait_stim(d);
        react_after(8);
        step(6);
        check("held_start_state", int'(u_if.oState), 3);
        u_if.iStart = 1'b0;
        step(1);

        // Held react through the stimulus: timeout
        u_if.iReact = 1'b1;
        step(1);
        check("held_react_state", int'(u_if.oState), 3);
        start_trial(1'b0, d);
        wait_stim(d);
        k = 0;
        while (!u_if.oResultValid && k < 45000) begin
            step(1);
            k++;
        end
        check("timeout_cycles", k, c_div * c_max);
        check("timeout_react",  int'(u_if.oReactMs), c_max);
        check("timeout_best",   int'(u_if.oBestMs), 5);
        check("timeout_stim",   int'(u_if.oStimulus), 0);
        u_if.iReact = 1'b0;
        step(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
